// File: rtl/q2_sequencer.sv
// q2_sequencer: timing and state generator for the control decoder.
//
// Each machine state lasts two clocks while running: phase 0 settles with ws low, and
// phase 1 writes with ws high. The state advances on the edge that ends phase 1.
// The front-panel run and step inputs are synchronised. The machine only ever halts in
// FETCH phase 0, so an instruction always runs to completion.
//
// Parameters:
//   SYNC_STAGES  flops per synchroniser for run_sw / step_sw (minimum 2)
//   ALU_FIRST    first ALU-step state code; ALU steps run ALU_FIRST..15
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   run_sw     run switch, asynchronous level
//   step_sw    single-step button, asynchronous level
//   op2        opcode bit 2 (indirect), valid from the first ADDR cycle
//   op5        opcode bit 5 (1 = store/jump class, no ALU steps)
//   s0..s3     machine state code {s3,s2,s1,s0}
//   ws         write strobe, high in phase 1 of each state
//   running    high while the sequencer is advancing states
//   inst_done  one-cycle pulse after a completed instruction returns to FETCH
module q2_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ALU_FIRST   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_sw,
    input  logic step_sw,
    input  logic op2,
    input  logic op5,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic running,
    output logic inst_done
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] LOAD     = 4'd2;
    localparam logic [3:0] EXEC     = 4'd3;
    localparam logic [3:0] ALU_CODE = 4'(ALU_FIRST);
    localparam logic [3:0] ALU_LAST = 4'hf;

    // Synchronisers and step edge detector
    logic [SYNC_STAGES-1:0] run_sync_q;
    logic [SYNC_STAGES-1:0] step_sync_q;
    logic                   step_prev_q;
    logic                   run_sync;
    logic                   step_sync;
    logic                   step_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_q  <= '0;
            step_sync_q <= '0;
            step_prev_q <= 1'b0;
        end else begin
            run_sync_q  <= {run_sync_q[SYNC_STAGES-2:0], run_sw};
            step_sync_q <= {step_sync_q[SYNC_STAGES-2:0], step_sw};
            step_prev_q <= step_sync;
        end
    end

    assign run_sync  = run_sync_q[SYNC_STAGES-1];
    assign step_sync = step_sync_q[SYNC_STAGES-1];
    assign step_go   = step_sync & ~step_prev_q;

    // Sequencer state
    logic [3:0] state_q;
    logic [3:0] state_nx;
    logic       phase_q;
    logic       deref_done_q;
    logic       deref_nx;
    logic       running_q;
    logic       ws_q;
    logic       inst_done_q;
    // Set by step_go from halt so the first FETCH phase 0 is not taken as a halt point.
    logic       step_armed_q;

    // Successor state, applied only at the end of phase 1
    always_comb begin
        state_nx = FETCH;
        deref_nx = deref_done_q;
        case (state_q)
            FETCH: begin
                state_nx = ADDR;
                deref_nx = 1'b0;
            end
            ADDR: begin
                // One extra ADDR pass for indirect; op2 is ignored on the second pass.
                if (op2 && !deref_done_q) begin
                    state_nx = ADDR;
                    deref_nx = 1'b1;
                end else begin
                    state_nx = LOAD;
                end
            end
            LOAD: state_nx = EXEC;
            EXEC: state_nx = op5 ? FETCH : ALU_CODE;
            default: begin
                if (state_q >= ALU_CODE && state_q != ALU_LAST) begin
                    state_nx = state_q + 4'd1;
                end else begin
                    // Last ALU step, or an illegal code below ALU_FIRST
                    state_nx = FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            phase_q      <= 1'b0;
            deref_done_q <= 1'b0;
            running_q    <= 1'b0;
            ws_q         <= 1'b0;
            inst_done_q  <= 1'b0;
            step_armed_q <= 1'b0;
        end else begin
            inst_done_q <= 1'b0;
            if (!running_q) begin
                // Halted in FETCH phase 0; run wins over a simultaneous step.
                phase_q <= 1'b0;
                ws_q    <= 1'b0;
                if (run_sync) begin
                    running_q <= 1'b1;
                end else if (step_go) begin
                    running_q    <= 1'b1;
                    step_armed_q <= 1'b1;
                end
            end else if (!phase_q) begin
                if (state_q == FETCH && !run_sync && !step_armed_q) begin
                    running_q <= 1'b0;
                    ws_q      <= 1'b0;
                end else begin
                    phase_q      <= 1'b1;
                    ws_q         <= 1'b1;
                    step_armed_q <= 1'b0;
                end
            end else begin
                phase_q      <= 1'b0;
                ws_q         <= 1'b0;
                state_q      <= state_nx;
                deref_done_q <= deref_nx;
                if (state_nx == FETCH) begin
                    inst_done_q <= 1'b1;
                end
            end
        end
    end

    assign s0        = state_q[0];
    assign s1        = state_q[1];
    assign s2        = state_q[2];
    assign s3        = state_q[3];
    assign ws        = ws_q;
    assign running   = running_q;
    assign inst_done = inst_done_q;

endmodule

// File: doc/q2_sequencer.md
Name: q2_sequencer

Overview:
- Sequential timing and state generator that drives the control decoder.
- Produces the 4-bit machine state (s0..s3) and the two-phase write strobe ws; the decoder turns these into register, memory and flag enables.
- Handles the front-panel run/step inputs and stops the machine cleanly on an instruction boundary (FETCH).

Parameters:
SYNC_STAGES, 2, number of flops in the synchronisers for the asynchronous run_sw and step_sw inputs (minimum 2)
ALU_FIRST, 4, first ALU-step state code; ALU steps run from ALU_FIRST to 15 inclusive

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
run_sw  input  1  front-panel run switch, asynchronous level
step_sw  input  1  front-panel single-step button, asynchronous level
op2  input  1  opcode bit 2 (indirect), valid from the first ADDR cycle onward
op5  input  1  opcode bit 5 (1 = non-ALU instruction: store/jump class)
s0  output  1  state bit 0
s1  output  1  state bit 1
s2  output  1  state bit 2
s3  output  1  state bit 3
ws  output  1  write strobe, high in phase 1 of each state
running  output  1  high while the sequencer is advancing states
inst_done  output  1  one-cycle pulse when a completed instruction returns to FETCH

Behaviour:
- Reset (rst_n=0, asynchronous): state = FETCH (0000), phase = 0, ws = 0, running = 0, inst_done = 0, synchronisers = 0, step edge-detector = 0.
- State code is {s3,s2,s1,s0}. Named states: FETCH=0000, ADDR=0001, LOAD=0010, EXEC=0011, ALU steps = ALU_FIRST..1111.
- Each state lasts exactly 2 clocks while running:
  - phase 0: ws = 0 (settle).
  - phase 1: ws = 1 (write).
  - The state advances on the clock edge that ends phase 1.
- ws is registered. It is never high while running = 0.
- Transitions, taken at the end of phase 1:
  - FETCH -> ADDR.
  - ADDR: if op2 = 1, stay in ADDR for one more state (second deref pass, tracked by an internal deref_done flag), then go to LOAD; if op2 = 0, go to LOAD directly.
  - LOAD: if op5 = 1, go to EXEC (LOAD is a no-op write slot for this class); if op5 = 0, go to EXEC.
  - EXEC: if op5 = 0, go to ALU_FIRST; if op5 = 1, go to FETCH.
  - ALU step n -> n+1; state 1111 -> FETCH. No wrap to 0000 from any other code.
- deref_done clears on entry to ADDR from FETCH. The second deref pass occurs only when op2 is 1 at the end of the first ADDR state; op2 is not re-sampled afterwards.
- inst_done pulses in the cycle after any transition into FETCH.
- Run control:
  - run_sw and step_sw each pass through a SYNC_STAGES flop chain.
  - step_go is a one-cycle pulse on the rising edge of synchronised step_sw.
  - run_sync = 1: running = 1, and the sequencer cycles indefinitely.
  - run_sync = 0 in FETCH phase 0: running = 0, and the state holds with ws = 0.
  - step_go while halted: running = 1 for exactly one instruction, then halt again in FETCH phase 0.
  - run_sync falling mid-instruction: the current instruction completes; the machine halts at the next FETCH phase 0. It never halts mid-instruction.
  - step_go while running or mid-step: ignored, with no queued step.
  - step_go and run_sync rising in the same cycle: run takes precedence and there is no double count.
- Illegal codes (0100..ALU_FIRST-1 when ALU_FIRST > 4): go to FETCH at the end of phase 1.
- Reset asserted mid-instruction: immediate return to FETCH phase 0 with ws = 0. No inst_done pulse is generated.

Test Plan:
- Release reset with run_sw=1, op2=0, op5=1 -> state sequence 0000,0001,0010,0011,0000, each for 2 clocks with ws on the 2nd; inst_done pulses once; 8 clocks per instruction.
- run_sw=1, op2=0, op5=0 -> after EXEC, states 0100..1111 (12 ALU steps) then 0000; 32 clocks per instruction; ws toggles every clock.
- op2=1, op5=1 -> ADDR is held for 2 states (4 clocks) before LOAD; 10 clocks per instruction.
- run_sw=0, pulse step_sw for 5 clocks -> after the sync latency (2 clocks), exactly one instruction executes; running falls and the state stays 0000 with ws=0; holding step_sw high gives no further instruction.
- Drop run_sw while in ALU state 0110 -> the remaining ALU steps complete, then halt at 0000 with running=0; inst_done pulses once.
- Assert rst_n=0 asynchronously while in EXEC phase 1 -> s0..s3=0 and ws=0 before the next clock edge; no inst_done pulse.
